// File: rtl/difftest_critical_error_collector.sv
// Multi-core critical-error collector: confirms per-core errors, latches the first
// record per core, and drains records in core order through a FWFT valid/ready FIFO.
module difftest_critical_error_collector #(
  parameter int NUM_CORES      = 4,
  parameter int COREID_W       = 8,
  parameter int TS_W           = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int CONFIRM_CYCLES = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_CORES-1:0]          io_valid,
  input  logic [NUM_CORES-1:0]          io_criticalError,
  input  logic [NUM_CORES*COREID_W-1:0] io_coreid,
  input  logic                          clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COREID_W-1:0]           out_coreid,
  output logic [TS_W-1:0]               out_timestamp,
  output logic                          out_first,
  output logic [NUM_CORES-1:0]          error_mask,
  output logic                          any_error,
  output logic                          halt_req,
  output logic [15:0]                   dropped_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [3:0]           CNT_SAT  = 4'(CONFIRM_CYCLES);
  localparam logic [3:0]           CNT_FIRE = 4'(CONFIRM_CYCLES - 1);
  localparam logic [AW:0]          DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [NUM_CORES-1:0] ONE      = NUM_CORES'(1);

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {12'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [3:0] sat_inc_cnt(input logic [3:0] c);
    return (c >= CNT_SAT) ? CNT_SAT : c + 4'd1;
  endfunction

  function automatic logic [4:0] popcount(input logic [NUM_CORES-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NUM_CORES; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  logic [TS_W-1:0]      ts_p0;
  logic [3:0]           cnt_p0 [NUM_CORES];
  logic [NUM_CORES-1:0] mask_p0;

  logic [NUM_CORES-1:0] vld_p1;
  logic [COREID_W-1:0]  rec_id_p1    [NUM_CORES];
  logic [TS_W-1:0]      rec_ts_p1    [NUM_CORES];
  logic [NUM_CORES-1:0] rec_first_p1;

  logic [COREID_W-1:0]  mem_id_p2    [FIFO_DEPTH];
  logic [TS_W-1:0]      mem_ts_p2    [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_first_p2;
  logic [AW:0]          wr_ptr_p2, rd_ptr_p2;

  logic [NUM_CORES-1:0] qual, fire, fire_low, first_vec, capture, drop, sel, mask_next;
  logic [IW-1:0]        sel_idx;
  logic [AW:0]          fill;
  logic                 push, pop, full, empty;

  // Stage 0: qualification, confirm counting, first-error arbitration
  assign qual      = {NUM_CORES{enable}} & io_valid & io_criticalError & ~mask_p0;
  assign fire_low  = fire & (~fire + ONE);
  assign first_vec = fire_low & {NUM_CORES{~any_error}};
  assign capture   = fire & ~vld_p1;
  assign drop      = fire & vld_p1;
  assign mask_next = (clear ? '0 : mask_p0) | fire;

  always_comb begin
    fire = '0;
    for (int i = 0; i < NUM_CORES; i++) fire[i] = qual[i] & (cnt_p0[i] == CNT_FIRE);
  end

  // Stage 1: per-core record slots, lowest pending index wins the FIFO push
  assign sel = vld_p1 & (~vld_p1 + ONE);

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) if (vld_p1[i]) sel_idx = IW'(i);
  end

  // Stage 2: first-word-fall-through record FIFO
  assign fill  = wr_ptr_p2 - rd_ptr_p2;
  assign full  = (fill == DEPTH);
  assign empty = (fill == '0);
  assign push  = (|vld_p1) & ~full;
  assign pop   = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      ts_p0         <= '0;
      mask_p0       <= '0;
      halt_req      <= 1'b0;
      dropped_count <= '0;
      vld_p1        <= '0;
      wr_ptr_p2     <= '0;
      rd_ptr_p2     <= '0;
      for (int i = 0; i < NUM_CORES; i++) cnt_p0[i] <= 4'd0;
    end else begin
      ts_p0         <= ts_p0 + TS_W'(1);
      mask_p0       <= mask_next;
      halt_req      <= |mask_next;
      dropped_count <= sat_add16(dropped_count, popcount(drop));
      vld_p1        <= (vld_p1 & ~(push ? sel : '0)) | capture;
      if (push) wr_ptr_p2 <= wr_ptr_p2 + (AW+1)'(1);
      if (pop)  rd_ptr_p2 <= rd_ptr_p2 + (AW+1)'(1);
      for (int i = 0; i < NUM_CORES; i++)
        cnt_p0[i] <= (clear || !qual[i]) ? 4'd0 : sat_inc_cnt(cnt_p0[i]);
    end
  end

  // Record payloads carry no reset; their valid bits and pointers gate them.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (capture[i]) begin
        rec_id_p1[i]    <= io_coreid[i*COREID_W +: COREID_W];
        rec_ts_p1[i]    <= ts_p0;
        rec_first_p1[i] <= first_vec[i];
      end
    end
    if (push) begin
      mem_id_p2[wr_ptr_p2[AW-1:0]]    <= rec_id_p1[sel_idx];
      mem_ts_p2[wr_ptr_p2[AW-1:0]]    <= rec_ts_p1[sel_idx];
      mem_first_p2[wr_ptr_p2[AW-1:0]] <= rec_first_p1[sel_idx];
    end
  end

  assign out_valid     = ~empty;
  assign out_coreid    = out_valid ? mem_id_p2[rd_ptr_p2[AW-1:0]] : '0;
  assign out_timestamp = out_valid ? mem_ts_p2[rd_ptr_p2[AW-1:0]] : '0;
  assign out_first     = out_valid & mem_first_p2[rd_ptr_p2[AW-1:0]];
  assign error_mask    = mask_p0;
  assign any_error     = |mask_p0;

endmodule

// File: tb/tb_difftest_critical_error_collector.sv
// Directed bench for the critical-error collector: three instances share stimulus
// (default, CONFIRM_CYCLES=3, FIFO_DEPTH=2); each scenario checks its own instance.
module tb_difftest_critical_error_collector;

  logic        clock = 1'b0;
  logic        reset, enable, clear, out_ready;
  logic [3:0]  io_valid, io_crit;
  logic [31:0] io_coreid;

  logic        a_vld, c_vld, f_vld;
  logic [7:0]  a_id, c_id, f_id;
  logic [31:0] a_ts, c_ts, f_ts;
  logic        a_first, c_first, f_first;
  logic [3:0]  a_mask, c_mask, f_mask;
  logic        a_any, c_any, f_any;
  logic        a_halt, c_halt, f_halt;
  logic [15:0] a_drop, c_drop, f_drop;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  difftest_critical_error_collector u_a (
    .clock(clock), .reset(reset), .enable(enable), .io_valid(io_valid),
    .io_criticalError(io_crit), .io_coreid(io_coreid), .clear(clear),
    .out_valid(a_vld), .out_ready(out_ready), .out_coreid(a_id),
    .out_timestamp(a_ts), .out_first(a_first), .error_mask(a_mask),
    .any_error(a_any), .halt_req(a_halt), .dropped_count(a_drop));

  difftest_critical_error_collector #(.CONFIRM_CYCLES(3)) u_c (
    .clock(clock), .reset(reset), .enable(enable), .io_valid(io_valid),
    .io_criticalError(io_crit), .io_coreid(io_coreid), .clear(clear),
    .out_valid(c_vld), .out_ready(out_ready), .out_coreid(c_id),
    .out_timestamp(c_ts), .out_first(c_first), .error_mask(c_mask),
    .any_error(c_any), .halt_req(c_halt), .dropped_count(c_drop));

  difftest_critical_error_collector #(.FIFO_DEPTH(2)) u_f (
    .clock(clock), .reset(reset), .enable(enable), .io_valid(io_valid),
    .io_criticalError(io_crit), .io_coreid(io_coreid), .clear(clear),
    .out_valid(f_vld), .out_ready(out_ready), .out_coreid(f_id),
    .out_timestamp(f_ts), .out_first(f_first), .error_mask(f_mask),
    .any_error(f_any), .halt_req(f_halt), .dropped_count(f_drop));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] v);
    io_valid = v;
    io_crit  = v;
  endtask

  // Leaves the bench in the first cycle after reset release (timestamp 0).
  task automatic do_reset();
    reset = 1'b0;
    drive(4'b0000);
    clear = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; clear = 1'b0; out_ready = 1'b1;
    io_valid = '0; io_crit = '0; io_coreid = '0;

    // Single error on core 2 at timestamp 10
    do_reset();
    chk("rst_valid", a_vld, 0);
    chk("rst_coreid", a_id, 0);
    chk("rst_ts", a_ts, 0);
    chk("rst_first", a_first, 0);
    chk("rst_mask", a_mask, 0);
    chk("rst_any", a_any, 0);
    chk("rst_halt", a_halt, 0);
    chk("rst_drop", a_drop, 0);
    step(10);
    io_coreid = 32'h0012_0000;
    drive(4'b0100);
    step();
    drive(4'b0000);
    chk("t1_mask", a_mask, 4'b0100);
    chk("t1_halt", a_halt, 1);
    chk("t1_any", a_any, 1);
    chk("t1_vld_early", a_vld, 0);
    step();
    chk("t1_vld", a_vld, 1);
    chk("t1_id", a_id, 8'h12);
    chk("t1_ts", a_ts, 10);
    chk("t1_first", a_first, 1);
    step();
    chk("t1_popped", a_vld, 0);

    // Cores 0, 1, 3 together at timestamp 5
    do_reset();
    step(5);
    io_coreid = 32'h4D00_2B1A;
    drive(4'b1011);
    step();
    drive(4'b0000);
    chk("t2_mask", a_mask, 4'b1011);
    step();
    chk("t2_id0", a_id, 8'h1A);
    chk("t2_ts0", a_ts, 5);
    chk("t2_first0", a_first, 1);
    step();
    chk("t2_id1", a_id, 8'h2B);
    chk("t2_ts1", a_ts, 5);
    chk("t2_first1", a_first, 0);
    step();
    chk("t2_id3", a_id, 8'h4D);
    chk("t2_ts3", a_ts, 5);
    chk("t2_first3", a_first, 0);
    step();
    chk("t2_empty", a_vld, 0);

    // CONFIRM_CYCLES=3: burst of 2, gap, burst of 3 on core 1
    do_reset();
    io_coreid = 32'h0000_7700;
    step();
    drive(4'b0010);
    step();
    step();
    drive(4'b0000);
    step();
    drive(4'b0010);
    chk("t3_mask_burst1", c_mask, 0);
    step(2);
    chk("t3_mask_pre", c_mask, 0);
    step();
    drive(4'b0000);
    chk("t3_mask", c_mask, 4'b0010);
    chk("t3_halt", c_halt, 1);
    step();
    chk("t3_vld", c_vld, 1);
    chk("t3_id", c_id, 8'h77);
    chk("t3_ts", c_ts, 6);
    chk("t3_first", c_first, 1);
    chk("t3_drop", c_drop, 0);
    step();
    chk("t3_single", c_vld, 0);

    // FIFO_DEPTH=2 backpressure with all four cores firing
    do_reset();
    out_ready = 1'b0;
    io_coreid = 32'hA3A2_A1A0;
    step();
    drive(4'b1111);
    step();
    drive(4'b0000);
    chk("t4_mask", f_mask, 4'b1111);
    chk("t4_vld_early", f_vld, 0);
    step();
    chk("t4_vld", f_vld, 1);
    chk("t4_head", f_id, 8'hA0);
    step(2);
    chk("t4_hold_id", f_id, 8'hA0);
    chk("t4_hold_ts", f_ts, 1);
    chk("t4_hold_first", f_first, 1);
    chk("t4_drop", f_drop, 0);
    out_ready = 1'b1;
    step();
    chk("t4_id1", f_id, 8'hA1);
    chk("t4_first1", f_first, 0);
    step();
    chk("t4_id2", f_id, 8'hA2);
    chk("t4_vld2", f_vld, 1);
    step();
    chk("t4_id3", f_id, 8'hA3);
    chk("t4_ts3", f_ts, 1);
    step();
    chk("t4_empty", f_vld, 0);

    // Drop: core 0 refires after clear while its record is still pending
    do_reset();
    out_ready = 1'b0;
    io_coreid = 32'h00C2_C1C0;
    step();
    drive(4'b0110);
    step();
    drive(4'b0000);
    step();
    drive(4'b0001);
    step();
    drive(4'b0000);
    clear = 1'b1;
    chk("t5_mask_pre", f_mask, 4'b0111);
    chk("t5_head_pre", f_id, 8'hC1);
    step();
    clear = 1'b0;
    drive(4'b0001);
    chk("t5_mask_clr", f_mask, 0);
    chk("t5_halt_clr", f_halt, 0);
    chk("t5_any_clr", f_any, 0);
    chk("t5_drop_pre", f_drop, 0);
    step();
    drive(4'b0000);
    chk("t5_drop", f_drop, 1);
    chk("t5_mask_again", f_mask, 4'b0001);
    chk("t5_halt_again", f_halt, 1);
    out_ready = 1'b1;
    step();
    chk("t5_id2", f_id, 8'hC2);
    step();
    chk("t5_id0", f_id, 8'hC0);
    chk("t5_ts0", f_ts, 3);
    chk("t5_first0", f_first, 0);
    step();
    chk("t5_empty", f_vld, 0);

    // Reset mid-drain with two records queued
    out_ready = 1'b0;
    io_coreid = 32'hD3D2_0000;
    drive(4'b1100);
    step();
    drive(4'b0000);
    step(2);
    chk("t6_vld_pre", f_vld, 1);
    chk("t6_head_pre", f_id, 8'hD2);
    chk("t6_drop_pre", f_drop, 1);
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t6_vld", f_vld, 0);
    chk("t6_mask", f_mask, 0);
    chk("t6_drop", f_drop, 0);
    chk("t6_halt", f_halt, 0);
    chk("t6_id", f_id, 0);
    chk("t6_ts", f_ts, 0);
    reset = 1'b1;
    io_coreid = 32'h00E2_0000;
    drive(4'b0100);
    step();
    drive(4'b0000);
    step();
    chk("t6_restart_vld", f_vld, 1);
    chk("t6_restart_id", f_id, 8'hE2);
    chk("t6_restart_ts", f_ts, 0);
    chk("t6_restart_first", f_first, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/difftest_critical_error_collector.md
Name: difftest_critical_error_collector

Overview:
- Multi-core successor to the single-core difftest critical-error event.
- Watches NUM_CORES per-core critical-error channels. Requires each error to persist for CONFIRM_CYCLES consecutive cycles before accepting it.
- Records the first confirmed error per core (core id plus timestamp) and drains the records through a FIFO with a valid/ready port to the difftest bridge.
- Maintains sticky error state, a halt request, and a counter of dropped events.

Parameters:
- NUM_CORES, 4: number of monitored cores/channels (1..16).
- COREID_W, 8: width of each core id.
- TS_W, 32: timestamp counter width.
- FIFO_DEPTH, 4: depth of the output record FIFO (power of two, ≥2).
- CONFIRM_CYCLES, 1: consecutive qualifying cycles required to confirm an error (1..15).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock, asserted when 0.
- enable  in  1  global qualifier; when 0, no channel qualifies.
- io_valid  in  NUM_CORES  per-core valid.
- io_criticalError  in  NUM_CORES  per-core critical-error flag.
- io_coreid  in  NUM_CORES*COREID_W  per-core id; core i occupies bits [i*COREID_W +: COREID_W].
- clear  in  1  single-cycle pulse that clears sticky state.
- out_valid  out  1  FIFO head record valid.
- out_ready  in  1  consumer accepts the head record.
- out_coreid  out  COREID_W  head record core id.
- out_timestamp  out  TS_W  head record timestamp.
- out_first  out  1  head record is the first error since reset or clear.
- error_mask  out  NUM_CORES  sticky per-core confirmed-error bits.
- any_error  out  1  OR-reduction of error_mask.
- halt_req  out  1  registered halt request.
- dropped_count  out  16  saturating count of dropped events.

Behaviour:
- **Reset (reset==0 at an edge):** all state cleared. out_valid=0, out_coreid=0, out_timestamp=0, out_first=0, error_mask=0, any_error=0, halt_req=0, dropped_count=0. Timestamp counter, confirm counters, pending bits and FIFO pointers all go to 0. Reset overrides every other input, including clear and out_ready.
- **Timestamp:** free-running, increments by 1 every non-reset cycle and wraps at 2^TS_W. It reads 0 in the first cycle after reset release.
- **Qualify:** core i qualifies in a cycle when enable & io_valid[i] & io_criticalError[i] & ~error_mask[i].
- **Confirm counter (per core):**
  - Increments, saturating at CONFIRM_CYCLES, while core i qualifies.
  - Resets to 0 on any non-qualifying cycle.
  - Fire[i] occurs in the cycle where the counter equals CONFIRM_CYCLES-1 and core i qualifies. With CONFIRM_CYCLES=1, the first qualifying cycle fires.
- **On fire[i] in cycle T:**
  - At the T edge: error_mask[i] is set. The record {io_coreid slice, timestamp value of cycle T, first flag} is captured into per-core record register i, and pending[i] is set.
  - any_error and halt_req become visible in cycle T+1.
  - The first flag is 1 only if any_error was 0 in cycle T and i is the lowest-index core firing in T.
- **Drop:** if pending[i] is still set when fire[i] occurs (only possible after a clear), the new event is discarded. The old record is kept and dropped_count increments, saturating at 0xFFFF.
- **Arbiter:** each cycle, the lowest-index pending record is pushed into the FIFO if the FIFO is not full, and its pending bit is cleared. This gives at most one push per cycle. A full FIFO stalls the arbiter; pending records are never lost.
- **FIFO:**
  - First-word-fall-through. A push at edge E makes the record visible at the head in cycle E+1 if the FIFO was empty.
  - A pop happens when out_valid & out_ready.
  - Simultaneous push and pop when full is not allowed; the arbiter uses the registered full flag.
  - Simultaneous push and pop when non-empty keeps the occupancy unchanged.
  - End-to-end latency with CONFIRM_CYCLES=1 and an empty FIFO: error in cycle T, out_valid in cycle T+2.
  - out_* hold stable while out_valid=1 and out_ready=0.
- **clear:**
  - Zeroes error_mask, any_error (next cycle), halt_req, and all confirm counters.
  - Pending records, FIFO contents and dropped_count are preserved.
  - If clear and fire[i] occur in the same cycle, the fire wins: error_mask[i]=1 afterwards and the record is captured.
- **halt_req:** equals the registered any_error; it holds until clear or reset.

Test Plan:
- Core 2 (coreid 0x12) errors at timestamp 10, CONFIRM_CYCLES=1, out_ready=1 -> error_mask=0b0100 and halt_req=1 at ts 11; out_valid at ts 12 with coreid 0x12, timestamp 10, out_first=1; popped next cycle.
- Cores 0, 1 and 3 error in the same cycle at ts 5 -> FIFO outputs in order core0 (first=1), core1 (first=0), core3 (first=0), all with timestamp 5, on consecutive cycles.
- CONFIRM_CYCLES=3; core 1 asserts for 2 cycles, drops for 1, then asserts for 3 cycles -> a single fire on the 3rd cycle of the second burst; the first burst is never recorded.
- FIFO_DEPTH=2, out_ready=0, 4 cores fire -> 2 records in the FIFO and 2 pending; no drops. Raising out_ready delivers all 4 records in core order.
- With out_ready=0, core 0 fires, then clear, then core 0 fires again while its record is still pending -> dropped_count=1. The original timestamp is delivered; error_mask[0]=1 again.
- Reset driven low mid-drain with 2 records queued -> next cycle out_valid=0, error_mask=0, dropped_count=0, timestamp restarts at 0.
